// File: rtl/fft_frame_packer.sv
// Serial-to-parallel complex sample packer feeding the FFT butterfly input word.
// Define FFT_PACK_BITREV_EN to store sample k in slot bitrev(k) for a DIT pipeline.
module fft_frame_packer #(
   parameter int N          = 2,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_WIDTH-1:0]     s_real,
   input  logic [DATA_WIDTH-1:0]     s_imag,
   input  logic                      s_last,
   output logic [DATA_WIDTH*2*N-1:0] cplx_data_out,
   output logic                      en_out,
   output logic                      frame_err,
   output logic [CNT_WIDTH-1:0]      frame_cnt
);

   localparam int IDX_W   = $clog2(N);
   localparam int FRAME_W = DATA_WIDTH * 2 * N;

   typedef enum logic {
      SYNC,
      FILL
   } state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [FRAME_W-1:0]   cap_q;
   logic [FRAME_W-1:0]   cap_d;
   logic [FRAME_W-1:0]   data_q;
   logic                 s_ready_q;
   logic                 en_q;
   logic                 err_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [IDX_W-1:0]     slot;
   logic                 accept;
   logic                 idx_last;

`ifdef FFT_PACK_BITREV_EN
   function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
      logic [IDX_W-1:0] r;
      for (int b = 0; b < IDX_W; b++) r[b] = v[IDX_W-1-b];
      return r;
   endfunction

   assign slot = bitrev(idx_q);
`else
   assign slot = idx_q;
`endif

   assign accept   = s_valid && s_ready_q;
   assign idx_last = (idx_q == IDX_W'(N - 1));

   // Capture word with the incoming sample merged in, so a completing frame can be
   // published in the same edge that accepts its last sample.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      cap_d = cap_q;
      for (int k = 0; k < N; k++) begin
         if (slot == IDX_W'(k)) begin
            cap_d[DATA_WIDTH*2*k     +: DATA_WIDTH] = s_real;
            cap_d[DATA_WIDTH*(2*k+1) +: DATA_WIDTH] = s_imag;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples the pre-edge value of every other register.
      if (rst) begin
         state_q   <= SYNC;
         idx_q     <= '0;
         // NOTE: the capture register is reset too; it is a plain flop bank, not a RAM,
         // and clearing it keeps post-reset behaviour fully deterministic.
         cap_q     <= '0;
         data_q    <= '0;
         s_ready_q <= 1'b0;
         en_q      <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s_ready_q <= 1'b1;
         en_q      <= 1'b0;
         err_q     <= 1'b0;
         if (accept) begin
            case (state_q)
               SYNC: begin
                  if (s_last) begin
                     state_q <= FILL;
                     idx_q   <= '0;
                  end
               end
               FILL: begin
                  cap_q <= cap_d;
                  if (idx_last) begin
                     idx_q <= '0;
                     if (s_last) begin
                        data_q <= cap_d;
                        en_q   <= 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                     end else begin
                        // Frame overran without a marker: alignment is lost, resync.
                        err_q   <= 1'b1;
                        state_q <= SYNC;
                     end
                  end else if (s_last) begin
                     err_q <= 1'b1;
                     idx_q <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
               default: state_q <= SYNC;
            endcase
         end
      end
   end

   assign s_ready       = s_ready_q;
   assign cplx_data_out = data_q;
   assign en_out        = en_q;
   assign frame_err     = err_q;
   assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Self-checking bench for fft_frame_packer: directed scenarios plus a randomized stream
// checked against a queue-based frame model.
module tb_fft_frame_packer;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int CW    = 4;
   localparam int LOGN  = $clog2(N);
   localparam int FW    = DW * 2 * N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_real = '0;
   logic [DW-1:0] s_imag = '0;
   logic          s_last = 1'b0;
   logic [FW-1:0] cplx_data_out;
   logic          en_out;
   logic          frame_err;
   logic [CW-1:0] frame_cnt;

   fft_frame_packer #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_real        (s_real),
      .s_imag        (s_imag),
      .s_last        (s_last),
      .cplx_data_out (cplx_data_out),
      .en_out        (en_out),
      .frame_err     (frame_err),
      .frame_cnt     (frame_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: framing rules expressed over a queue of the current frame's samples.
   logic [2*DW-1:0] frame_q[$];
   bit              synced;
   logic            ready_m;
   logic            exp_en;
   logic            exp_err;
   logic [FW-1:0]   exp_data;
   logic [CW-1:0]   exp_cnt;

   function automatic int slot_of(int k);
      int r = k;
`ifdef FFT_PACK_BITREV_EN
      r = 0;
      for (int b = 0; b < LOGN; b++) if (((k >> b) & 1) != 0) r |= 1 << (LOGN - 1 - b);
`endif
      return r;
   endfunction

   function automatic logic [FW-1:0] pack_frame();
      logic [FW-1:0] w = '0;
      for (int k = 0; k < N; k++) begin
         w[2*DW*slot_of(k) +: 2*DW] = frame_q[k];
      end
      return w;
   endfunction

   task automatic do_reset(input int cycles);
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      frame_q.delete();
      synced   = 0;
      ready_m  = 1'b0;
      exp_en   = 1'b0;
      exp_err  = 1'b0;
      exp_data = '0;
      exp_cnt  = '0;
      rst      = 1'b0;
   endtask

   // Drive one cycle of input, then advance the model to the post-edge expectation.
   task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                       input logic l);
      bit acc;
      s_valid = v;
      s_real  = re;
      s_imag  = im;
      s_last  = l;
      @(posedge clk);
      #1;
      acc     = v && ready_m;
      exp_en  = 1'b0;
      exp_err = 1'b0;
      if (acc) begin
         if (!synced) begin
            if (l) synced = 1;
         end else begin
            frame_q.push_back({im, re});
            if (l) begin
               if (frame_q.size() == N) begin
                  exp_data = pack_frame();
                  exp_en   = 1'b1;
                  exp_cnt  = exp_cnt + 1'b1;
               end else begin
                  exp_err = 1'b1;
               end
               frame_q.delete();
            end else if (frame_q.size() == N) begin
               exp_err = 1'b1;
               synced  = 0;
               frame_q.delete();
            end
         end
      end
      ready_m = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      n_vec++;
      if ({s_ready, en_out, frame_err, frame_cnt, cplx_data_out} !== {1'b0, 1'b0, 1'b0, CW'(0), FW'(0)}) begin
         n_err++;
         $display("FAIL reset_values: got rdy=%b en=%b err=%b cnt=%0d data=%h, want all zero",
                  s_ready, en_out, frame_err, frame_cnt, cplx_data_out);
      end
      step(1'b0, '0, '0, 1'b0);
      n_vec++;
      if (s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_reset: got %b want 1", s_ready);
      end
   endtask

   task automatic test_basic();
      logic [FW-1:0] want;
`ifdef FFT_PACK_BITREV_EN
      want = {16'hFFFC, 16'h0004, 16'hFFFE, 16'h0002, 16'hFFFD, 16'h0003, 16'hFFFF, 16'h0001};
`else
      want = {16'hFFFC, 16'h0004, 16'hFFFD, 16'h0003, 16'hFFFE, 16'h0002, 16'hFFFF, 16'h0001};
`endif
      step(1'b1, 16'h1234, 16'h5678, 1'b1);
      for (int k = 1; k <= N; k++) begin
         step(1'b1, DW'(k), DW'(-k), k == N);
         n_vec++;
         if ({en_out, frame_err, frame_cnt, cplx_data_out} !== {exp_en, exp_err, exp_cnt, exp_data}) begin
            n_err++;
            $display("FAIL basic_k%0d: got en=%b err=%b cnt=%0d data=%h want en=%b err=%b cnt=%0d data=%h",
                     k, en_out, frame_err, frame_cnt, cplx_data_out, exp_en, exp_err, exp_cnt, exp_data);
         end
      end
      n_vec++;
      if ({en_out, frame_cnt, cplx_data_out} !== {1'b1, CW'(1), want}) begin
         n_err++;
         $display("FAIL basic_word: got en=%b cnt=%0d data=%h want en=1 cnt=1 data=%h",
                  en_out, frame_cnt, cplx_data_out, want);
      end
      step(1'b0, '0, '0, 1'b0);
      n_vec++;
      if ({en_out, cplx_data_out} !== {1'b0, want}) begin
         n_err++;
         $display("FAIL basic_hold: got en=%b data=%h want en=0 data=%h", en_out, cplx_data_out, want);
      end
   endtask

   task automatic test_gaps();
      for (int k = 1; k <= N; k++) begin
         step(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
         n_vec++;
         if ({en_out, frame_err} !== 2'b00) begin
            n_err++;
            $display("FAIL gaps_idle_k%0d: got en=%b err=%b want 0 0", k, en_out, frame_err);
         end
         step(1'b1, DW'(k), DW'(-k), k == N);
         n_vec++;
         if ({en_out, frame_err, frame_cnt, cplx_data_out} !== {exp_en, exp_err, exp_cnt, exp_data}) begin
            n_err++;
            $display("FAIL gaps_k%0d: got en=%b err=%b cnt=%0d data=%h want en=%b err=%b cnt=%0d data=%h",
                     k, en_out, frame_err, frame_cnt, cplx_data_out, exp_en, exp_err, exp_cnt, exp_data);
         end
      end
   endtask

   task automatic test_short_frame();
      logic [CW-1:0] cnt_before = exp_cnt;
      step(1'b1, 16'h0101, 16'h0202, 1'b0);
      step(1'b1, 16'h0303, 16'h0404, 1'b1);
      n_vec++;
      if ({en_out, frame_err, frame_cnt} !== {1'b0, 1'b1, cnt_before}) begin
         n_err++;
         $display("FAIL short_err: got en=%b err=%b cnt=%0d want en=0 err=1 cnt=%0d",
                  en_out, frame_err, frame_cnt, cnt_before);
      end
      for (int k = 0; k < N; k++) begin
         step(1'b1, DW'($urandom), DW'($urandom), k == N - 1);
         n_vec++;
         if ({en_out, frame_err, frame_cnt, cplx_data_out} !== {exp_en, exp_err, exp_cnt, exp_data}) begin
            n_err++;
            $display("FAIL short_next_k%0d: got en=%b err=%b cnt=%0d data=%h want en=%b err=%b cnt=%0d data=%h",
                     k, en_out, frame_err, frame_cnt, cplx_data_out, exp_en, exp_err, exp_cnt, exp_data);
         end
      end
   endtask

   task automatic test_long_frame();
      for (int k = 0; k < N; k++) step(1'b1, DW'(k + 7), DW'(k + 9), 1'b0);
      n_vec++;
      if ({en_out, frame_err} !== 2'b01) begin
         n_err++;
         $display("FAIL long_err: got en=%b err=%b want en=0 err=1", en_out, frame_err);
      end
      // Dropped while resyncing: N full-looking samples, then the marker sample.
      for (int k = 0; k <= N; k++) begin
         step(1'b1, DW'($urandom), DW'($urandom), k == N);
         n_vec++;
         if ({en_out, frame_err} !== 2'b00) begin
            n_err++;
            $display("FAIL long_drop_k%0d: got en=%b err=%b want 0 0", k, en_out, frame_err);
         end
      end
      for (int k = 0; k < N; k++) begin
         step(1'b1, DW'($urandom), DW'($urandom), k == N - 1);
         n_vec++;
         if ({en_out, frame_err, frame_cnt, cplx_data_out} !== {exp_en, exp_err, exp_cnt, exp_data}) begin
            n_err++;
            $display("FAIL long_resume_k%0d: got en=%b err=%b cnt=%0d data=%h want en=%b err=%b cnt=%0d data=%h",
                     k, en_out, frame_err, frame_cnt, cplx_data_out, exp_en, exp_err, exp_cnt, exp_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 16'h1111, 16'h2222, 1'b0);
      step(1'b1, 16'h3333, 16'h4444, 1'b0);
      do_reset(1);
      n_vec++;
      if ({s_ready, en_out, frame_err, frame_cnt, cplx_data_out} !== {1'b0, 1'b0, 1'b0, CW'(0), FW'(0)}) begin
         n_err++;
         $display("FAIL midrst_values: got rdy=%b en=%b err=%b cnt=%0d data=%h, want all zero",
                  s_ready, en_out, frame_err, frame_cnt, cplx_data_out);
      end
      step(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < N; k++) begin
         step(1'b1, DW'(k), DW'(k), k == N - 1);
         n_vec++;
         if ({s_ready, en_out, frame_err, frame_cnt} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
            n_err++;
            $display("FAIL midrst_after_k%0d: got rdy=%b en=%b err=%b cnt=%0d want rdy=1 en=0 err=0 cnt=0",
                     k, s_ready, en_out, frame_err, frame_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      int last_en = -1;
      int cyc = 0;
      for (int f = 0; f < 2 ** CW + 3; f++) begin
         for (int k = 0; k < N; k++) begin
            step(1'b1, DW'($urandom), DW'($urandom), k == N - 1);
            cyc++;
            n_vec++;
            if ({en_out, frame_err, frame_cnt, cplx_data_out} !== {exp_en, exp_err, exp_cnt, exp_data}) begin
               n_err++;
               $display("FAIL b2b_f%0d_k%0d: got en=%b err=%b cnt=%0d data=%h want en=%b err=%b cnt=%0d data=%h",
                        f, k, en_out, frame_err, frame_cnt, cplx_data_out, exp_en, exp_err, exp_cnt, exp_data);
            end
            if (en_out === 1'b1) begin
               if (last_en >= 0) begin
                  n_vec++;
                  if (cyc - last_en != N) begin
                     n_err++;
                     $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc - last_en, N);
                  end
               end
               last_en = cyc;
            end
         end
      end
   endtask

   task automatic test_random();
      int pos = 0;
      int len = N;
      for (int i = 0; i < 1500; i++) begin
         bit v = ($urandom % 4) != 0;
         bit l = 1'b0;
         if (v) begin
            l = (pos == len - 1);
            pos++;
            if (l) begin
               pos = 0;
               len = (($urandom % 5) != 0) ? N : int'($urandom_range(1, N + 2));
            end
         end
         step(v, DW'($urandom), DW'($urandom), l);
         n_vec++;
         if ({s_ready, en_out, frame_err, frame_cnt, cplx_data_out} !== {ready_m, exp_en, exp_err, exp_cnt, exp_data}) begin
            n_err++;
            $display("FAIL random_i%0d: got en=%b err=%b cnt=%0d data=%h want en=%b err=%b cnt=%0d data=%h",
                     i, en_out, frame_err, frame_cnt, cplx_data_out, exp_en, exp_err, exp_cnt, exp_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_short_frame();
      test_long_frame();
      test_reset_mid();
      step(1'b1, '0, '0, 1'b1);
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
